reg_file_8x16: RTL and testbench
================================

REG_FILE_8X16 -- requirements
Module: reg_file_8x16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of every register and data port.
REQ-002 SHALL have parameter R0_ZERO, default 1; 1 = register 0 hardwired to zero, 0 = register 0 writable.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 WE  input  1  write enable for this cycle.
REQ-006 WA  input  3  write address (register 0..7).
REQ-007 WD  input  WIDTH  write data.
REQ-008 RA  input  3  read port A address.
REQ-009 RB  input  3  read port B address.
REQ-010 DA  output  WIDTH  registered read data, port A.
REQ-011 DB  output  WIDTH  registered read data, port B.
REQ-012 q0..q7  output  WIDTH each  current contents of registers 0..7; these drive in0..in7 of the downstream 16-bit 8-to-1 mux.
REQ-013 WERR  output  1  registered flag: last cycle attempted a write to register 0 while R0_ZERO=1.

Function
REQ-014 SHALL hold 8 registers R0..R7 of WIDTH bits.
REQ-015 On a rising CLK edge with RST=0, WE=1, SHALL load R[WA] <= WD; all other registers hold.
REQ-016 With WE=0, SHALL hold all registers; WA/WD are don't-care.
REQ-017 With R0_ZERO=1, writes to WA=0 SHALL be discarded, R0 SHALL read as 0, and WERR SHALL be 1 in the following cycle; otherwise WERR SHALL be 0.
REQ-018 With R0_ZERO=0, R0 SHALL behave as R1..R7 and WERR SHALL stay 0.
REQ-019 q0..q7 SHALL be driven directly from register state (no combinational path from WD) and SHALL show a write one cycle after the write edge.
REQ-020 DA/DB SHALL have 1-cycle latency: value sampled at edge N is R[RA]/R[RB] as of edge N, returned on DA/DB after edge N.
REQ-021 Write-read collision: if WE=1 and WA==RA (resp. RB) at the same edge, and the write is not discarded, DA (resp. DB) SHALL capture WD (write-first bypass).
REQ-022 Collision on a discarded R0 write SHALL return 0 on the colliding read port.
REQ-023 RA==RB SHALL return identical values on DA and DB, including under bypass.
REQ-024 Address fields SHALL be exactly 3 bits; no out-of-range address exists, no wrap logic needed.
REQ-025 No X SHALL propagate to q0..q7, DA, DB or WERR after the first reset edge, for any known input.

Reset
REQ-026 While RST=1 at a rising edge, SHALL clear R0..R7, DA, DB and WERR to 0; WE is ignored at that edge.
REQ-027 RST SHALL take priority over a simultaneous write; a write asserted in the reset cycle SHALL be lost.
REQ-028 First write SHALL be accepted at the first edge with RST=0.
REQ-029 Reset asserted mid-sequence SHALL clear all state in one edge with no partial-write residue.

Verification
REQ-030 Reset, then write R1..R7 = 11,22,33,44,55,66,77 (decimal) on successive cycles -> q1..q7 = 11..77, q0 = 0; then sweep the downstream mux select 0..7 -> O = 0,11,...,77.
REQ-031 R0_ZERO=1: WE=1, WA=0, WD=16'hFFFF -> q0 stays 0, WERR=1 for one cycle; same edge RA=0 -> DA=0.
REQ-032 Bypass: R3=33 held, same edge WE=1, WA=3, WD=16'h1234, RA=3, RB=3 -> after edge DA=DB=16'h1234, q3=16'h1234.
REQ-033 Dual read: R5=55, R6=66, RA=5, RB=6, WE=0 -> DA=55, DB=66 one cycle later, registers unchanged.
REQ-034 Reset priority: RST=1 and WE=1, WA=2, WD=16'hABCD at the same edge -> q2=0, DA=DB=0, WERR=0.
REQ-035 Mid-sequence reset: after REQ-030 load, assert RST for one edge -> q0..q7 all 0 next cycle; a write at the following edge to R7=16'h0007 -> q7=7 only.

Source files
------------

// File: rtl/reg_file_8x16.sv
// reg_file_8x16: eight WIDTH-bit registers with one write port and two
// registered read ports. Register 0 can be hardwired to zero; a write
// aimed at it is then dropped and flagged on o_werr for one cycle.
// Reads are write-first: a read addressing the register written at the
// same edge returns the new data, or zero if that write is dropped.
module reg_file_8x16 #(
  parameter int WIDTH   = 16,
  parameter int R0_ZERO = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [2:0]       i_wa,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [2:0]       i_ra,
  input  logic [2:0]       i_rb,
  output logic [WIDTH-1:0] o_da,
  output logic [WIDTH-1:0] o_db,
  output logic [WIDTH-1:0] o_q0,
  output logic [WIDTH-1:0] o_q1,
  output logic [WIDTH-1:0] o_q2,
  output logic [WIDTH-1:0] o_q3,
  output logic [WIDTH-1:0] o_q4,
  output logic [WIDTH-1:0] o_q5,
  output logic [WIDTH-1:0] o_q6,
  output logic [WIDTH-1:0] o_q7,
  output logic             o_werr
);

  localparam bit LP_R0_ZERO = (R0_ZERO != 0);

  logic [WIDTH-1:0] r_regs [8];
  logic [WIDTH-1:0] r_da;
  logic [WIDTH-1:0] r_db;
  logic             r_werr;

  logic             w_r0_hit;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  // a write is dropped only when it targets a hardwired-zero R0
  assign w_r0_hit = LP_R0_ZERO && (i_wa == 3'd0);
  assign w_wr_ok  = i_we && !w_r0_hit;

  // write-first read selection for both ports; a hardwired R0 always reads 0
  always_comb begin
    w_rd_a = r_regs[i_ra];
    w_rd_b = r_regs[i_rb];
    if (LP_R0_ZERO && (i_ra == 3'd0)) w_rd_a = '0;
    if (LP_R0_ZERO && (i_rb == 3'd0)) w_rd_b = '0;
    if (w_wr_ok && (i_wa == i_ra))    w_rd_a = i_wd;
    if (w_wr_ok && (i_wa == i_rb))    w_rd_b = i_wd;
  end

  // register array: reset wins over any write at the same edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 8; k++) r_regs[k] <= '0;
    end else if (w_wr_ok) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // registered read data and dropped-write flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_da   <= '0;
      r_db   <= '0;
      r_werr <= 1'b0;
    end else begin
      r_da   <= w_rd_a;
      r_db   <= w_rd_b;
      r_werr <= i_we && w_r0_hit;
    end
  end

  assign o_da   = r_da;
  assign o_db   = r_db;
  assign o_werr = r_werr;

  // R0 is forced to zero at the output too, so it is clean even before reset
  assign o_q0 = LP_R0_ZERO ? '0 : r_regs[0];
  assign o_q1 = r_regs[1];
  assign o_q2 = r_regs[2];
  assign o_q3 = r_regs[3];
  assign o_q4 = r_regs[4];
  assign o_q5 = r_regs[5];
  assign o_q6 = r_regs[6];
  assign o_q7 = r_regs[7];

endmodule

// File: tb/tb_reg_file_8x16.sv
// Testbench for reg_file_8x16: table of stimulus/expected records pushed
// through a scoreboard queue, plus hand sequences for the downstream mux
// sweep, mid-sequence reset and the writable-R0 variant.
module tb_reg_file_8x16;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         we;
  logic [2:0]   wa;
  logic [W-1:0] wd;
  logic [2:0]   ra;
  logic [2:0]   rb;

  logic [W-1:0] da, db, q0, q1, q2, q3, q4, q5, q6, q7;
  logic         werr;
  logic [W-1:0] da_n, db_n, n0, n1, n2, n3, n4, n5, n6, n7;
  logic         werr_n;

  reg_file_8x16 #(.WIDTH(W), .R0_ZERO(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_wa(wa), .i_wd(wd),
    .i_ra(ra), .i_rb(rb), .o_da(da), .o_db(db),
    .o_q0(q0), .o_q1(q1), .o_q2(q2), .o_q3(q3),
    .o_q4(q4), .o_q5(q5), .o_q6(q6), .o_q7(q7), .o_werr(werr)
  );

  reg_file_8x16 #(.WIDTH(W), .R0_ZERO(0)) dut_nz (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_wa(wa), .i_wd(wd),
    .i_ra(ra), .i_rb(rb), .o_da(da_n), .o_db(db_n),
    .o_q0(n0), .o_q1(n1), .o_q2(n2), .o_q3(n3),
    .o_q4(n4), .o_q5(n5), .o_q6(n6), .o_q7(n7), .o_werr(werr_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream 8-to-1 mux fed by q0..q7
  logic [2:0]   sel;
  logic [W-1:0] mux_o;
  always_comb begin
    case (sel)
      3'd0:    mux_o = q0;
      3'd1:    mux_o = q1;
      3'd2:    mux_o = q2;
      3'd3:    mux_o = q3;
      3'd4:    mux_o = q4;
      3'd5:    mux_o = q5;
      3'd6:    mux_o = q6;
      default: mux_o = q7;
    endcase
  end

  typedef struct {
    logic         rst;
    logic         we;
    logic [2:0]   wa;
    logic [W-1:0] wd;
    logic [2:0]   ra;
    logic [2:0]   rb;
    logic [W-1:0] exp_da;
    logic [W-1:0] exp_db;
    logic         exp_werr;
    int           qi;
    logic [W-1:0] exp_q;
  } vec_t;

  vec_t tbl [16];
  vec_t sb [$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [W-1:0] q_of(input int i);
    case (i)
      0: q_of = q0;
      1: q_of = q1;
      2: q_of = q2;
      3: q_of = q3;
      4: q_of = q4;
      5: q_of = q5;
      6: q_of = q6;
      default: q_of = q7;
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic [2:0] a,
                       input logic [W-1:0] d, input logic [2:0] x, input logic [2:0] y);
    @(negedge clk);
    rst = r; we = e; wa = a; wd = d; ra = x; rb = y;
    @(posedge clk);
    #1;
  endtask

  // apply table entries lo..hi: push expectation when driving, pop after the edge
  task automatic run_vectors(input int lo, input int hi);
    vec_t e;
    for (int i = lo; i <= hi; i++) begin
      sb.push_back(tbl[i]);
      drive(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb);
      if (sb.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1 at vector %0d", i);
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_da", i), da, e.exp_da);
        check($sformatf("v%0d_db", i), db, e.exp_db);
        check($sformatf("v%0d_werr", i), {{(W-1){1'b0}}, werr}, {{(W-1){1'b0}}, e.exp_werr});
        check($sformatf("v%0d_q%0d", i, e.qi), q_of(e.qi), e.exp_q);
      end
    end
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic [2:0] a,
                              input logic [W-1:0] d, input logic [2:0] x, input logic [2:0] y,
                              input logic [W-1:0] xa, input logic [W-1:0] xb,
                              input logic xw, input int qi, input logic [W-1:0] xq);
    vec_t v;
    v.rst = r; v.we = e; v.wa = a; v.wd = d; v.ra = x; v.rb = y;
    v.exp_da = xa; v.exp_db = xb; v.exp_werr = xw; v.qi = qi; v.exp_q = xq;
    return v;
  endfunction

  logic [W-1:0] load_vals [8];

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0; sel = '0;
    load_vals[0] = 16'd0;
    for (int k = 1; k < 8; k++) load_vals[k] = W'(11 * k);

    //          rst we  wa  wd        ra  rb   da       db       werr qi q
    tbl[0]  = mk(1, 1, 2, 16'hABCD, 2, 2, 16'd0,   16'd0,   0, 2, 16'd0);
    tbl[1]  = mk(0, 1, 1, 16'd11,   0, 1, 16'd0,   16'd11,  0, 1, 16'd11);
    tbl[2]  = mk(0, 1, 2, 16'd22,   1, 2, 16'd11,  16'd22,  0, 2, 16'd22);
    tbl[3]  = mk(0, 1, 3, 16'd33,   2, 3, 16'd22,  16'd33,  0, 3, 16'd33);
    tbl[4]  = mk(0, 1, 4, 16'd44,   3, 1, 16'd33,  16'd11,  0, 4, 16'd44);
    tbl[5]  = mk(0, 1, 5, 16'd55,   4, 4, 16'd44,  16'd44,  0, 5, 16'd55);
    tbl[6]  = mk(0, 1, 6, 16'd66,   0, 5, 16'd0,   16'd55,  0, 6, 16'd66);
    tbl[7]  = mk(0, 1, 7, 16'd77,   7, 6, 16'd77,  16'd66,  0, 7, 16'd77);
    tbl[8]  = mk(0, 0, 7, 16'h0000, 5, 6, 16'd55,  16'd66,  0, 5, 16'd55);
    tbl[9]  = mk(0, 0, 5, 16'hDEAD, 5, 6, 16'd55,  16'd66,  0, 6, 16'd66);
    tbl[10] = mk(0, 1, 0, 16'hFFFF, 0, 7, 16'd0,   16'd77,  1, 0, 16'd0);
    tbl[11] = mk(0, 0, 0, 16'hFFFF, 1, 2, 16'd11,  16'd22,  0, 0, 16'd0);
    tbl[12] = mk(0, 1, 3, 16'h1234, 3, 3, 16'h1234, 16'h1234, 0, 3, 16'h1234);
    tbl[13] = mk(0, 1, 0, 16'h5555, 0, 0, 16'd0,   16'd0,   1, 0, 16'd0);
    tbl[14] = mk(0, 1, 0, 16'h0001, 2, 2, 16'd22,  16'd22,  1, 2, 16'd22);
    tbl[15] = mk(0, 0, 0, 16'h0001, 7, 4, 16'd77,  16'd44,  0, 7, 16'd77);

    run_vectors(0, 9);

    // sweep the downstream mux across the freshly loaded registers
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      sel = 3'(s);
      #1;
      check($sformatf("mux_sel%0d", s), mux_o, load_vals[s]);
    end

    run_vectors(10, 15);

    // reload R3 so the mid-sequence reset hits a fully loaded file
    drive(0, 1, 3, 16'd33, 0, 0);
    check("reload_q3", q3, 16'd33);

    drive(1, 0, 0, 16'h0000, 7, 3);
    for (int k = 0; k < 8; k++) check($sformatf("rst_q%0d", k), q_of(k), 16'd0);
    check("rst_da", da, 16'd0);
    check("rst_db", db, 16'd0);
    check("rst_werr", {{(W-1){1'b0}}, werr}, 16'd0);

    drive(0, 1, 7, 16'h0007, 1, 7);
    for (int k = 0; k < 8; k++) check($sformatf("post_q%0d", k), q_of(k), (k == 7) ? 16'h0007 : 16'd0);
    check("post_db_bypass", db, 16'h0007);

    // R0 writable variant vs hardwired variant on the same stimulus
    drive(0, 1, 0, 16'hBEEF, 0, 1);
    check("nz_q0", n0, 16'hBEEF);
    check("nz_da", da_n, 16'hBEEF);
    check("nz_werr", {{(W-1){1'b0}}, werr_n}, 16'd0);
    check("z_q0", q0, 16'd0);
    check("z_da", da, 16'd0);
    check("z_werr", {{(W-1){1'b0}}, werr}, 16'd1);

    drive(0, 0, 0, 16'h0000, 0, 0);
    check("nz_hold_da", da_n, 16'hBEEF);
    check("nz_hold_db", db_n, 16'hBEEF);
    check("z_werr_clear", {{(W-1){1'b0}}, werr}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
